// File: rtl/test_port_writer_pkg.sv
// Shared constants and types for the test-port reporting writer.
// The frame symbols here are defaults; the top can override them per instance.
package test_port_pkg;

   localparam logic [29:0] TEST_PORT_DEFAULT = 30'hFF;
   localparam logic [31:0] BEGIN_SYM_DEFAULT = 32'h0000_0168;
   localparam logic [31:0] END_SYM_DEFAULT   = 32'h0000_0D5D;

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_BEGIN = 3'd1,
      ST_GAP      = 3'd2,
      ST_WAIT_RES = 3'd3,
      ST_WR_RES   = 3'd4,
      ST_WR_END   = 3'd5,
      ST_DONE     = 3'd6
   } state_e;

   // States that drive a memory write; everything else keeps mem_wen low.
   function automatic logic is_write_state(input state_e s);
      return (s == ST_WR_BEGIN) || (s == ST_WR_RES) || (s == ST_WR_END);
   endfunction

endpackage

// File: rtl/test_port_writer_sync_fifo.sv
// Small synchronous FIFO with a combinational head, used to buffer result words.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   always_comb begin
      count    = wr_ptr_q - rd_ptr_q;
      full     = (count == (AW+1)'(DEPTH));
      empty    = (count == '0);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: emptiness is defined purely by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/test_port_writer.sv
// Frames buffered result words as BEGIN / results / END writes to the test port,
// with a one-cycle write-enable gap between writes so each is seen exactly once.
module test_port_writer
   import test_port_pkg::*;
#(
   parameter logic [29:0] TEST_PORT   = TEST_PORT_DEFAULT,
   parameter logic [31:0] BEGIN_SYM   = BEGIN_SYM_DEFAULT,
   parameter logic [31:0] END_SYM     = END_SYM_DEFAULT,
   parameter int          NUM_RESULTS = 2,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        res_valid,
   input  logic [31:0] res_data,
   output logic        res_ready,
   input  logic        mem_stall,
   output logic        mem_wen,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic [7:0]  sent_count
);

   localparam logic [7:0] NUM_RES8 = 8'(NUM_RESULTS);

   state_e      state_q, state_d;
   logic        mem_wen_q, mem_wen_d;
   logic [29:0] mem_addr_q, mem_addr_d;
   word_t       mem_wdata_q, mem_wdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  sent_count_q, sent_count_d;

   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   word_t       fifo_head;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   assign fifo_push = res_valid && !fifo_full;

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_res_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (res_data),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d      = state_q;
      sent_count_d = sent_count_q;
      fifo_pop     = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d      = ST_WR_BEGIN;
               sent_count_d = '0;
            end
         end
         ST_WR_BEGIN: begin
            if (!mem_stall) state_d = ST_GAP;
         end
         ST_GAP: begin
            if (sent_count_q >= NUM_RES8) state_d = ST_WR_END;
            else if (fifo_count != '0)    state_d = ST_WR_RES;
            else                          state_d = ST_WAIT_RES;
         end
         ST_WAIT_RES: begin
            if (!fifo_empty) state_d = ST_WR_RES;
         end
         ST_WR_RES: begin
            // The head is only retired once the memory has taken it.
            if (!mem_stall) begin
               state_d  = ST_GAP;
               fifo_pop = 1'b1;
               if (sent_count_q < NUM_RES8) sent_count_d = sent_count_q + 8'd1;
            end
         end
         ST_WR_END: begin
            if (!mem_stall) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are a registered function of the next state, so a stalled
      // write keeps identical wen/addr/data until it completes.
      mem_wen_d  = is_write_state(state_d);
      mem_addr_d = mem_wen_d ? TEST_PORT : '0;
      unique case (state_d)
         ST_WR_BEGIN: mem_wdata_d = BEGIN_SYM;
         ST_WR_RES:   mem_wdata_d = fifo_head;
         ST_WR_END:   mem_wdata_d = END_SYM;
         default:     mem_wdata_d = '0;
      endcase
      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         mem_wen_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         sent_count_q <= '0;
      end else begin
         state_q      <= state_d;
         mem_wen_q    <= mem_wen_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         sent_count_q <= sent_count_d;
      end
   end

   assign res_ready  = !fifo_full;
   assign mem_wen    = mem_wen_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign sent_count = sent_count_q;

endmodule

// File: tb/tb_test_port_writer.sv
// Directed and randomized frames checked against a queue-based model of the
// expected write sequence (BEGIN, oldest NUM_RESULTS buffered words, END).
module tb_test_port_writer;

   localparam logic [29:0] PORT  = 30'hFF;
   localparam logic [31:0] BSYM  = 32'h0000_0168;
   localparam logic [31:0] ESYM  = 32'h0000_0D5D;
   localparam int          NRES  = 2;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        res_valid = 1'b0;
   logic [31:0] res_data = 32'd0;
   logic        mem_stall = 1'b0;
   logic        res_ready;
   logic        mem_wen;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic [7:0]  sent_count;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] model_q[$];
   logic [31:0] obs_q[$];
   int          pend_t[$];
   logic [31:0] pend_v[$];
   int          wen_cycles = 0;
   logic        prev_wen = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = 32'd0;

   test_port_writer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_ready  (res_ready),
      .mem_stall  (mem_stall),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .sent_count (sent_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write monitor: a write counts once, on the cycle it is not stalled.
   always @(negedge clk) begin
      if (!rst) begin
         prev_wen <= 1'b0;
      end else begin
         if (mem_wen) begin
            wen_cycles <= wen_cycles + 1;
            chk("wen_addr", 32'(mem_addr), 32'(PORT));
            if (prev_wen) begin
               chk("wen_gap", 32'(prev_stall), 32'd1);
               chk("wen_hold", mem_wdata, prev_data);
            end
            if (!mem_stall) obs_q.push_back(mem_wdata);
         end else begin
            chk("idle_addr", 32'(mem_addr), 32'd0);
            chk("idle_data", mem_wdata, 32'd0);
         end
         prev_wen   <= mem_wen;
         prev_stall <= mem_stall;
         prev_data  <= mem_wdata;
      end
   end

   task automatic push_word(input logic [31:0] w);
      int n;
      n = 0;
      res_valid = 1'b1;
      res_data  = w;
      while (!res_ready && n < 50) begin
         tick();
         n++;
      end
      chk("push_accept", 32'(res_ready), 32'd1);
      tick();
      model_q.push_back(w);
      res_valid = 1'b0;
   endtask

   task automatic run_frame(input string tag, input int exp_cycles,
                            input logic [31:0] stall_word, input int stall_n,
                            input bit rand_stall, input int busy_start_cyc,
                            input int probe1, input int probe2, input int exp_wen);
      int cyc, done_cyc, stall_left, obs_base, wen_base;
      logic acc;
      obs_base = obs_q.size();
      wen_base = wen_cycles;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_start_done"}, 32'(done), 32'd0);
      chk({tag, "_start_busy"}, 32'(busy), 32'd1);
      chk({tag, "_start_cnt"}, 32'(sent_count), 32'd0);
      cyc = 1;
      done_cyc = 0;
      stall_left = stall_n;
      while ((done_cyc == 0 || pend_v.size() != 0 || res_valid) && cyc < 400) begin
         if (rand_stall) begin
            mem_stall = ($urandom_range(0, 3) == 0);
         end else if (stall_left > 0 && mem_wen && mem_wdata == stall_word) begin
            mem_stall = 1'b1;
            stall_left--;
         end else begin
            mem_stall = 1'b0;
         end
         start = (cyc == busy_start_cyc);
         if (cyc == probe1 || cyc == probe2) begin
            chk($sformatf("%s_park_wen%0d", tag, cyc), 32'(mem_wen), 32'd0);
            chk($sformatf("%s_park_busy%0d", tag, cyc), 32'(busy), 32'd1);
         end
         if (!res_valid && pend_v.size() != 0 && pend_t[0] <= cyc) begin
            res_valid = 1'b1;
            res_data  = pend_v.pop_front();
            void'(pend_t.pop_front());
         end
         acc = res_valid && res_ready;
         tick();
         cyc++;
         if (acc) begin
            model_q.push_back(res_data);
            res_valid = 1'b0;
         end
         if (done && done_cyc == 0) done_cyc = cyc - 1;
      end
      mem_stall = 1'b0;
      start = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_sent"}, 32'(sent_count), 32'(NRES));
      if (exp_cycles >= 0) chk({tag, "_cycles"}, 32'(done_cyc), 32'(exp_cycles));
      if (exp_wen >= 0) chk({tag, "_wen_cycles"}, 32'(wen_cycles - wen_base), 32'(exp_wen));
      chk({tag, "_nwrites"}, 32'(obs_q.size() - obs_base), 32'(NRES + 2));
      for (int i = 0; i < NRES + 2; i++) begin
         logic [31:0] e, o;
         if (i == 0) e = BSYM;
         else if (i == NRES + 1) e = ESYM;
         else e = (model_q.size() >= i) ? model_q[i-1] : 32'hBAD0_BAD0;
         o = (obs_q.size() > obs_base + i) ? obs_q[obs_base + i] : 32'hDEAD_BEEF;
         chk($sformatf("%s_word%0d", tag, i), o, e);
      end
      for (int i = 0; i < NRES; i++) begin
         if (model_q.size() != 0) void'(model_q.pop_front());
      end
      $display("frame %s: cycles=%0d writes=%0d", tag, done_cyc, obs_q.size() - obs_base);
   endtask

   initial begin
      int n;
      // Reset state.
      repeat (2) tick();
      chk("rst_wen", 32'(mem_wen), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_data", mem_wdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cnt", 32'(sent_count), 32'd0);
      chk("rst_ready", 32'(res_ready), 32'd1);
      rst = 1'b1;
      tick();

      // Pre-buffered frame, no stall: 2*NRES+3 cycles.
      push_word(32'd40320);
      push_word(32'd1);
      run_frame("t1", 2*NRES + 3, 32'd0, 0, 1'b0, 0, 0, 0, NRES + 2);

      // Three stall cycles on the first result word.
      push_word(32'd40320);
      push_word(32'd1);
      run_frame("t2", 2*NRES + 6, 32'd40320, 3, 1'b0, 0, 0, 0, NRES + 5);

      // Empty FIFO at start: parks waiting for results.
      pend_t.push_back(10); pend_v.push_back(32'd40320);
      pend_t.push_back(20); pend_v.push_back(32'd1);
      run_frame("t3", -1, 32'd0, 0, 1'b0, 0, 9, 19, NRES + 2);

      // Overfill: fifth word must wait for the first pop.
      for (int k = 1; k <= DEPTH; k++) push_word(32'h1000_0000 + 32'(k));
      chk("t4_ready_full", 32'(res_ready), 32'(model_q.size() < DEPTH));
      res_valid = 1'b1;
      res_data  = 32'h1000_0005;
      repeat (3) tick();
      chk("t4_ready_held", 32'(res_ready), 32'd0);
      res_valid = 1'b0;
      pend_t.push_back(1); pend_v.push_back(32'h1000_0005);
      run_frame("t4a", 2*NRES + 3, 32'd0, 0, 1'b0, 0, 0, 0, NRES + 2);
      run_frame("t4b", 2*NRES + 3, 32'd0, 0, 1'b0, 0, 0, 0, NRES + 2);

      // Start while busy is ignored; start from DONE begins a fresh frame.
      push_word(32'h1000_0006);
      run_frame("t6", 2*NRES + 3, 32'd0, 0, 1'b0, 3, 0, 0, NRES + 2);

      // Asynchronous reset during a stalled result write.
      push_word(32'hA5A5_0001);
      push_word(32'hA5A5_0002);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(mem_wen && mem_wdata == 32'hA5A5_0001) && n < 20) begin
         tick();
         n++;
      end
      chk("t5_reach_res", 32'(n < 20), 32'd1);
      mem_stall = 1'b1;
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("t5_async_wen", 32'(mem_wen), 32'd0);
      chk("t5_async_busy", 32'(busy), 32'd0);
      chk("t5_async_addr", 32'(mem_addr), 32'd0);
      chk("t5_async_cnt", 32'(sent_count), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      mem_stall = 1'b0;
      model_q.delete();
      repeat (3) tick();
      chk("t5_post_ready", 32'(res_ready), 32'd1);
      chk("t5_post_wen", 32'(mem_wen), 32'd0);
      chk("t5_post_busy", 32'(busy), 32'd0);
      chk("t5_post_done", 32'(done), 32'd0);
      pend_t.push_back(12); pend_v.push_back(32'hC0DE_0001);
      pend_t.push_back(13); pend_v.push_back(32'hC0DE_0002);
      run_frame("t5", -1, 32'd0, 0, 1'b0, 0, 10, 0, NRES + 2);

      // Randomized data, push timing and stalls.
      for (int f = 0; f < 8; f++) begin
         int need;
         need = NRES - model_q.size();
         if (need < 0) need = 0;
         if (model_q.size() < NRES && $urandom_range(0, 1) == 1) need++;
         for (int k = 0; k < need; k++) begin
            pend_t.push_back(int'($urandom_range(1, 15)));
            pend_v.push_back($urandom);
         end
         run_frame($sformatf("rnd%0d", f), -1, 32'd0, 0, 1'b1, 0, 0, 0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/test_port_writer.md
Name: test_port_writer

Overview:
Synthesizable producer side of the test-port reporting protocol. It accepts computed results over a valid/ready stream and emits them as framed memory-style writes to the test port address: a begin symbol, then the results, then the end symbol. It sits between the datapath's result source and the data-memory write interface. It honours memory stall, and it separates consecutive writes with a write-enable low gap so a monitor can count each write exactly once.

Parameters:
TEST_PORT, 30'hFF, word address driven on every write
BEGIN_SYM, 32'h00000168, first word of a frame
END_SYM, 32'h00000D5D, last word of a frame
NUM_RESULTS, 2, result words per frame (1..255)
FIFO_DEPTH, 4, result buffer entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  pulse; begins a frame when in IDLE or DONE, ignored otherwise
res_valid  in  1  result word offered
res_data  in  32  result word
res_ready  out  1  buffer can accept; transfer on res_valid&&res_ready at posedge
mem_stall  in  1  memory not ready; current write must be held
mem_wen  out  1  write enable
mem_addr  out  30  write address, always TEST_PORT when mem_wen=1, else 0
mem_wdata  out  32  write data, 0 when mem_wen=0
busy  out  1  high from start acceptance until DONE is entered
done  out  1  high in DONE, sticky until next start or reset
sent_count  out  8  result words written in the current frame

Behaviour:
- Reset values: mem_wen=0, mem_addr=0, mem_wdata=0, busy=0, done=0, sent_count=0, FIFO empty, res_ready=1, state IDLE. Reset mid-frame aborts immediately; there is no partial-frame recovery.
- All outputs except res_ready are registered. res_ready = !fifo_full, and the FIFO accepts results in any state, including IDLE.
- States: IDLE, WR_BEGIN, GAP, WAIT_RES, WR_RES, WR_END, DONE.
- IDLE/DONE with start=1:
  - next state WR_BEGIN; busy=1; done=0; sent_count=0.
  - The FIFO is not flushed.
- Write state rule (WR_BEGIN, WR_RES, WR_END):
  - mem_wen=1; mem_addr=TEST_PORT; mem_wdata=word.
  - Word is BEGIN_SYM, FIFO head, or END_SYM respectively.
  - A write completes at a posedge with mem_stall=0.
  - While mem_stall=1, wen, addr and data stay constant.
- After WR_BEGIN or WR_RES completes: GAP for exactly one cycle (mem_wen=0).
- GAP exit:
  - To WR_END if sent_count==NUM_RESULTS.
  - Else to WR_RES if the FIFO is non-empty.
  - Else to WAIT_RES.
- WAIT_RES: mem_wen=0; moves to WR_RES on the cycle after the FIFO becomes non-empty.
- FIFO pop and count: the head is popped and sent_count is incremented in the same edge that completes WR_RES.
- WR_END completion: next state DONE; mem_wen=0; busy=0; done=1.
- Minimum frame length with no stall and results pre-buffered: 2*NUM_RESULTS+3 cycles from start to done (5+2*NUM_RESULTS-2 … i.e. 7 for NUM_RESULTS=2).
- Simultaneous push and pop on the same edge are both performed; the count is unchanged.
- A push when full is impossible because res_ready=0.
- sent_count saturates at NUM_RESULTS.
- Extra buffered results beyond NUM_RESULTS remain in the FIFO for the next frame.
- The block never emits two consecutive cycles of mem_wen=1 belonging to different words.

Decomposition:
- Package test_port_pkg:
  - TEST_PORT, BEGIN_SYM and END_SYM default constants.
  - State enum typedef (3-bit encoding).
  - 32-bit word typedef.
- One sub-module: sync_fifo (parameterized width/depth, push/pop, full/empty, count). It is instantiated for result buffering.
- The FSM and output registers live in test_port_writer.

Test Plan:
- Pre-push 40320 and 1, pulse start, mem_stall=0 → writes 0x168, 40320, 1, 0xD5D at addr 0xFF, each 1 cycle, wen low 1 cycle between; done after 7 cycles; sent_count=2.
- Same as above, but mem_stall=1 for 3 cycles during the 40320 write → wen/addr/data held 4 cycles; no duplicate write; the frame finishes 3 cycles later.
- Start with an empty FIFO; push 40320 ten cycles later and 1 twenty cycles later → parks in WAIT_RES with wen=0; the writes follow each push; END is emitted only after the second.
- Push 5 words with FIFO_DEPTH=4 → res_ready drops after 4; the 5th is accepted after the first pop; the frame sends the first two; the next start sends words 3 and 4.
- Assert rst mid-WR_RES with stall held → mem_wen=0 and busy=0 asynchronously; after release, state is IDLE and the FIFO is empty.
- start pulsed while busy → ignored; frame content unchanged; start in DONE → a new frame begins and done clears.
